mc_datapath: RTL and testbench
==============================

Name: mc_datapath

Overview:
- Multicycle MIPS-32 datapath: the consumer of the control word issued by the multicycle control unit.
- Holds PC, IR, MDR, A/B operand registers, ALUOut, a 32x32 register file and the ALU.
- Drives the unified instruction/data memory port.
- Returns Op/Funct to the control unit each cycle.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DATA_W, 32, datapath width; fixed at 32, any other value unsupported

Ports:
CLK  in  1  clock, all state updates on posedge
CLR  in  1  asynchronous active-low reset
PCWrite  in  1  unconditional PC load
BranchEq  in  1  PC load when ALU Zero=1
BranchNeq  in  1  PC load when ALU Zero=0
IorD  in  1  memory address select: 0=PC, 1=ALUOut
MemWrite  in  1  memory write request
IRWrite  in  1  IR load enable
RegDst  in  1  write register select: 0=rt IR[20:16], 1=rd IR[15:11]
MemtoReg  in  1  write data select: 0=ALUOut, 1=MDR
RegWrite  in  1  register file write enable
ALUSrcA  in  1  ALU A select: 0=PC, 1=A reg
ALUSrcB  in  2  ALU B select: 00=B reg, 01=32'd4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUControl  in  3  000 add, 001 sub, 010 and, 011 or, 100 nor, 101 slt (signed), 110 sll, 111 srl
PCSrc  in  1  PC next select: 0=ALU result (comb), 1=ALUOut
MemAddr  out  32  memory address
MemWData  out  32  memory write data (= B reg)
MemWE  out  1  memory write enable (= MemWrite)
MemRData  in  32  memory read data, combinational, valid same cycle as MemAddr
Op  out  6  IR[31:26]
Funct  out  6  IR[5:0]
PC_dbg  out  32  current PC

Behaviour:
- Reset (CLR low, async):
  - PC=RESET_PC.
  - IR, MDR, A, B, ALUOut and all 32 registers = 0.
  - Outputs therefore reset as: Op=0, Funct=0, MemAddr=RESET_PC, MemWE=0.
  - Reset dominates every enable.
- Register loading:
  - IR loads MemRData only when IRWrite=1.
  - MDR, A (rf[IR[25:21]]), B (rf[IR[20:16]]) and ALUOut (ALU result) load on every cycle.
  - Result: a value produced in cycle N is consumed in cycle N+1.
- PC load: PC loads when PCWrite | (BranchEq & Zero) | (BranchNeq & ~Zero).
  - Next PC = ALU result when PCSrc=0, ALUOut when PCSrc=1.
  - Multiple load terms true in the same cycle produce a single load.
- Zero flag: combinational, ALU result == 0, computed in the same cycle.
- ALU:
  - Add/sub are 32-bit modulo; no overflow trap.
  - slt yields 32'd1 or 32'd0, signed compare.
  - sll/srl shift the ALU B operand by IR[10:6]; srl is logical.
  - Sign extension of IR[15:0] to 32 bits.
- Register file:
  - Write port active at posedge when RegWrite=1; address and data selected per RegDst and MemtoReg.
  - Writes to r0 are ignored; r0 always reads 0.
  - Read ports are combinational.
  - No write-to-read bypass: a same-cycle write and read of the same register gives A/B the old value.
- Memory port:
  - MemAddr = PC when IorD=0, ALUOut when IorD=1.
  - MemWE is a combinational pass-through of MemWrite; no internal memory.
- Control word timing: all control inputs are sampled as levels in the cycle they are presented; no latching.
- Fetch (PCWrite, IRWrite, ALUSrcB=01, ALUControl=add): IR <= mem[PC] and PC <= PC+4 on the same edge.
- All-zero control word: only the free-running registers (MDR, A, B, ALUOut) update. PC, IR and the register file hold.

Decomposition:
- Shared package (alongside the existing opcode package):
  - ALUControl encodings.
  - ALUSrcB select encodings.
  - RESET_PC default.
- One natural sub-module: mc_alu (combinational ALU plus Zero).
- The register file stays inline; it is small.

Test Plan:
1. Reset while PC=0x20 and IR nonzero, CLR low mid-cycle -> PC=0, Op=0, Funct=0 and MemAddr=0 immediately, without waiting for a clock edge.
2. Fetch, mem[0]=0x20090005 (addi $9,$0,5), control 8410 -> after edge IR=0x20090005, Op=6'h08, PC=4. Then ID 0000, EX 0060, WB 0080 -> rf[9]=5.
3. add sequence, rf[9]=5, rf[10]=7, IR=0x012A5820 (add $11,$9,$10), EX 0240 then WB 0280 -> rf[11]=12; rf[9] and rf[10] unchanged.
4. Write to r0: RegDst=1, rd=0, ALUOut=0xFFFF, RegWrite=1 -> rf[0] still reads 0, A=0 next cycle.
5. Branch: A=B=3, ALUControl=sub, ALUSrcA=1, ALUSrcB=00, BranchEq=1, PCSrc=1, ALUOut=0x40 -> PC=0x40. Same with BranchNeq=1 instead -> PC unchanged.
6. Store path: ALUOut=0x100, B=0xDEADBEEF, IorD=1, MemWrite=1 -> MemAddr=0x100, MemWData=0xDEADBEEF, MemWE=1 in the same cycle. MemWrite=0 -> MemWE=0.

Source files
------------

// File: rtl/mc_datapath_pkg.sv
// Shared definitions for the multicycle MIPS-32 datapath.
//   - ALU control and ALU B-source encodings (match the control word fields)
//   - Default reset PC
//   - Instruction field view and immediate sign extension
package mc_datapath_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctl_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_e;

  // R-type field view of IR; the I-type immediate is {rd, shamt, funct}.
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } ir_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU with Zero flag.
//   a_i, b_i  : operands
//   shamt_i   : shift amount for sll/srl (shifts b_i)
//   ctl_i     : operation select
//   y_o       : result
//   zero_o    : y_o == 0
module mc_alu
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [4:0]        shamt_i,
  input  alu_ctl_e          ctl_i,
  output logic [DATA_W-1:0] y_o,
  output logic              zero_o
);

  always_comb begin
    y_o = '0;
    case (ctl_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_NOR: y_o = ~(a_i | b_i);
      ALU_SLT: y_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLL: y_o = b_i << shamt_i;
      ALU_SRL: y_o = b_i >> shamt_i;
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS-32 datapath driven by the multicycle control unit.
// Holds PC, IR, MDR, A, B, ALUOut, a 32x32 register file and the ALU, and
// drives a unified instruction/data memory port.
//   CLK, CLR        : clock, async active-low reset
//   PCWrite..PCSrc  : control word, sampled as levels each cycle
//   MemAddr/MemWData/MemWE/MemRData : memory port (read data combinational)
//   Op, Funct       : IR[31:26], IR[5:0] back to the control unit
//   PC_dbg          : current PC
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              PCWrite,
  input  logic              BranchEq,
  input  logic              BranchNeq,
  input  logic              IorD,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic              RegDst,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              ALUSrcA,
  input  logic [1:0]        ALUSrcB,
  input  logic [2:0]        ALUControl,
  input  logic              PCSrc,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWE,
  input  logic [DATA_W-1:0] MemRData,
  output logic [5:0]        Op,
  output logic [5:0]        Funct,
  output logic [DATA_W-1:0] PC_dbg
);

  logic [DATA_W-1:0] pc_q, pc_d, mdr_q, a_q, b_q, aluout_q;
  ir_t               ir_q;
  logic [DATA_W-1:0] rf_q [32];

  logic [DATA_W-1:0] src_a, src_b, alu_y, imm_sx, wdata, rd_a, rd_b;
  logic [4:0]        waddr;
  logic              zero, pc_en;

  assign imm_sx = sext16({ir_q.rd, ir_q.shamt, ir_q.funct});

  // r0 is never written, but force the read to zero so it cannot depend
  // on reset having cleared it.
  assign rd_a = (ir_q.rs == 5'd0) ? '0 : rf_q[ir_q.rs];
  assign rd_b = (ir_q.rt == 5'd0) ? '0 : rf_q[ir_q.rt];

  assign src_a = ALUSrcA ? a_q : pc_q;

  always_comb begin
    src_b = b_q;
    case (srcb_e'(ALUSrcB))
      SRCB_B:      src_b = b_q;
      SRCB_FOUR:   src_b = 32'd4;
      SRCB_IMM:    src_b = imm_sx;
      SRCB_IMM_SH: src_b = imm_sx << 2;
      default:     src_b = b_q;
    endcase
  end

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i     (src_a),
    .b_i     (src_b),
    .shamt_i (ir_q.shamt),
    .ctl_i   (alu_ctl_e'(ALUControl)),
    .y_o     (alu_y),
    .zero_o  (zero)
  );

  assign pc_en = PCWrite | (BranchEq & zero) | (BranchNeq & ~zero);
  assign pc_d  = PCSrc ? aluout_q : alu_y;
  assign waddr = RegDst ? ir_q.rd : ir_q.rt;
  assign wdata = MemtoReg ? mdr_q : aluout_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (pc_en)   pc_q <= pc_d;
      if (IRWrite) ir_q <= ir_t'(MemRData);
      // Free-running pipeline registers: A/B see the pre-write register
      // values because the file update lands on the same edge.
      mdr_q    <= MemRData;
      a_q      <= rd_a;
      b_q      <= rd_b;
      aluout_q <= alu_y;
      if (RegWrite && waddr != 5'd0) rf_q[waddr] <= wdata;
    end
  end

  assign MemAddr  = IorD ? aluout_q : pc_q;
  assign MemWData = b_q;
  assign MemWE    = MemWrite;
  assign Op       = ir_q.op;
  assign Funct    = ir_q.funct;
  assign PC_dbg   = pc_q;

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;

  logic        CLK, CLR;
  logic        PCWrite, BranchEq, BranchNeq, IorD, MemWrite, IRWrite;
  logic        RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [31:0] MemAddr, MemWData, MemRData, PC_dbg;
  logic        MemWE;
  logic [5:0]  Op, Funct;

  logic [31:0] mem [256];
  assign MemRData = mem[MemAddr[9:2]];

  mc_datapath dut (
    .CLK(CLK), .CLR(CLR), .PCWrite(PCWrite), .BranchEq(BranchEq),
    .BranchNeq(BranchNeq), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemRData(MemRData),
    .Op(Op), .Funct(Funct), .PC_dbg(PC_dbg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Architectural reference state
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_alo;
  logic [31:0] m_rf [32];

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] sh);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return ~(x | y);
      3'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd6: return y << sh;
      default: return y >> sh;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_alo = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endtask

  task automatic setc(input logic pcw, input logic beq, input logic bne, input logic iord,
                      input logic mw, input logic irw, input logic rdst, input logic m2r,
                      input logic rw, input logic sa, input logic [1:0] sb,
                      input logic [2:0] ac, input logic ps);
    PCWrite = pcw; BranchEq = beq; BranchNeq = bne; IorD = iord; MemWrite = mw;
    IRWrite = irw; RegDst = rdst; MemtoReg = m2r; RegWrite = rw; ALUSrcA = sa;
    ALUSrcB = sb; ALUControl = ac; PCSrc = ps;
  endtask

  // One clock: check the combinational outputs against the model, then
  // advance the model by the effect of the current control word.
  task automatic step();
    logic [31:0] sa, sb, y, imm, maddr, rdv, wd, an, bn, bold;
    logic [4:0]  wa;
    logic        z, ld;
    #1;
    imm = {{16{m_ir[15]}}, m_ir[15:0]};
    sa  = ALUSrcA ? m_a : m_pc;
    case (ALUSrcB)
      2'd0: sb = m_b;
      2'd1: sb = 32'd4;
      2'd2: sb = imm;
      default: sb = imm << 2;
    endcase
    y     = ref_alu(ALUControl, sa, sb, m_ir[10:6]);
    z     = (y == 32'd0);
    maddr = IorD ? m_alo : m_pc;
    chk("MemAddr", MemAddr, maddr);
    chk("MemWData", MemWData, m_b);
    chk("MemWE", {31'd0, MemWE}, {31'd0, MemWrite});
    chk("Op", {26'd0, Op}, {26'd0, m_ir[31:26]});
    chk("Funct", {26'd0, Funct}, {26'd0, m_ir[5:0]});
    chk("PC", PC_dbg, m_pc);
    rdv  = mem[maddr[9:2]];
    bold = m_b;
    @(posedge CLK);
    ld = PCWrite || (BranchEq && z) || (BranchNeq && !z);
    wa = RegDst ? m_ir[15:11] : m_ir[20:16];
    wd = MemtoReg ? m_mdr : m_alo;
    an = m_rf[m_ir[25:21]];
    bn = m_rf[m_ir[20:16]];
    if (RegWrite && wa != 5'd0) m_rf[wa] = wd;
    if (ld) m_pc = PCSrc ? m_alo : y;
    if (IRWrite) m_ir = rdv;
    m_mdr = rdv; m_a = an; m_b = bn; m_alo = y;
    @(negedge CLK);
    if (MemWrite) mem[maddr[9:2]] = bold;
  endtask

  task automatic idle();  setc(0,0,0,0,0,0,0,0,0,0,2'd0,3'd0,0); endtask
  task automatic fetch(); setc(1,0,0,0,0,1,0,0,0,0,2'd1,3'd0,0); step(); endtask
  task automatic id_();   idle(); step(); endtask
  task automatic ex_imm(); setc(0,0,0,0,0,0,0,0,0,1,2'd2,3'd0,0); step(); endtask
  task automatic wb_rt(); setc(0,0,0,0,0,0,0,0,1,0,2'd0,3'd0,0); step(); endtask

  initial begin
    logic [14:0] cw;
    idle();
    CLR = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h8C00_0000 | (i * 32'h41);
    model_reset();
    #1;
    chk("rst_PC", PC_dbg, 32'h0);
    chk("rst_Op", {26'd0, Op}, 32'h0);
    chk("rst_MemAddr", MemAddr, 32'h0);
    chk("rst_MemWE", {31'd0, MemWE}, 32'h0);
    @(negedge CLK);
    CLR = 1'b1;

    // Advance PC to 0x20 with a nonzero IR, then reset mid-cycle.
    for (int i = 0; i < 8; i++) fetch();
    idle();
    chk("pre_PC", PC_dbg, 32'h20);
    chk("pre_Op", {26'd0, Op}, 32'h23);
    #2 CLR = 1'b0;
    #1;
    chk("mid_rst_PC", PC_dbg, 32'h0);
    chk("mid_rst_Op", {26'd0, Op}, 32'h0);
    chk("mid_rst_Funct", {26'd0, Funct}, 32'h0);
    chk("mid_rst_MemAddr", MemAddr, 32'h0);
    model_reset();
    @(negedge CLK);
    CLR = 1'b1;

    // Program image
    mem[0]  = 32'h2009_0005;  // addi $9,$0,5
    mem[1]  = 32'h200A_0007;  // addi $10,$0,7
    mem[2]  = 32'h012A_5820;  // add $11,$9,$10
    mem[3]  = 32'h0169_0000;  // rs=11 rt=9 probe
    mem[4]  = 32'h0000_0000;  // rd=0
    mem[5]  = 32'h200C_0003;  // addi $12,$0,3
    mem[6]  = 32'h118C_0004;  // beq $12,$12,+4
    mem[11] = 32'h118C_0004;  // same, at 0x2C
    mem[12] = 32'h8C0D_0080;  // lw $13,0x80($0)
    mem[13] = 32'hAC0D_0100;  // sw $13,0x100($0)
    mem[32] = 32'hDEAD_BEEF;

    fetch();
    chk("fetch_Op", {26'd0, Op}, 32'h08);
    chk("fetch_PC", PC_dbg, 32'h4);
    id_(); ex_imm(); wb_rt();
    id_();
    chk("rf9_via_B", MemWData, 32'd5);

    fetch(); id_(); ex_imm(); wb_rt();
    fetch(); id_();
    setc(0,0,0,0,0,0,0,0,0,1,2'd0,3'd0,0); step();   // EX add
    setc(0,0,0,0,0,0,1,0,1,0,2'd0,3'd0,0); step();   // WB rd
    fetch(); id_();
    chk("rf9_unchanged", MemWData, 32'd5);
    setc(0,0,0,0,0,0,0,0,0,1,2'd2,3'd0,0); step();   // ALUOut = A + 0
    setc(0,0,0,1,0,0,0,0,0,0,2'd0,3'd0,0); #1;
    chk("rf11_sum", MemAddr, 32'd12);
    step();

    // r0 write attempt
    fetch();
    setc(0,0,0,0,0,0,0,0,0,0,2'd1,3'd0,0); step();   // ALUOut = PC+4 (nonzero)
    setc(0,0,0,0,0,0,1,0,1,0,2'd0,3'd0,0); step();   // write rd=0
    id_();
    setc(0,0,0,0,0,0,0,0,0,1,2'd2,3'd0,0); step();
    setc(0,0,0,1,0,0,0,0,0,0,2'd0,3'd0,0); #1;
    chk("r0_reads_zero", MemAddr, 32'd0);
    step();

    // Branches
    fetch(); id_(); ex_imm(); wb_rt();
    fetch();
    setc(0,0,0,0,0,0,0,0,0,0,2'd3,3'd0,0); step();   // ALUOut = PC + 16
    setc(0,1,0,0,0,0,0,0,0,1,2'd0,3'd1,1); step();   // beq taken
    chk("beq_taken_PC", PC_dbg, 32'h2C);
    fetch();
    setc(0,0,0,0,0,0,0,0,0,0,2'd3,3'd0,0); step();
    setc(0,0,1,0,0,0,0,0,0,1,2'd0,3'd1,1); step();   // bne not taken
    chk("bne_hold_PC", PC_dbg, 32'h30);

    // Load then store
    fetch(); id_(); ex_imm();
    setc(0,0,0,1,0,0,0,0,0,0,2'd0,3'd0,0); step();   // memory read
    setc(0,0,0,0,0,0,0,1,1,0,2'd0,3'd0,0); step();   // WB from MDR
    fetch(); id_(); ex_imm();
    setc(0,0,0,1,1,0,0,0,0,0,2'd0,3'd0,0); #1;
    chk("st_MemAddr", MemAddr, 32'h100);
    chk("st_MemWData", MemWData, 32'hDEAD_BEEF);
    chk("st_MemWE", {31'd0, MemWE}, 32'd1);
    step();
    idle(); #1;
    chk("st_MemWE_off", {31'd0, MemWE}, 32'd0);
    chk("st_mem_written", mem[64], 32'hDEAD_BEEF);

    // Randomized control words against the model
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      cw = 15'($urandom);
      {PCWrite, BranchEq, BranchNeq, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
       RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc} = cw;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
